// File: rtl/riscv_test_pkg.sv
// Shared definitions for the RV32I end-of-test monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_test_pkg;

  // Monitor states; everything except ST_RUN is terminal and sticky until clear.
  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } state_t;

  // rv32ui-p tohost location.
  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h8000_1000;

  // x3 (gp) holds the current test number in the rv32ui-p harness.
  localparam logic [4:0] GP_REG = 5'd3;

  // Reported when tohost receives an even nonzero value (not a valid encoding).
  localparam logic [30:0] MALFORMED_TESTNUM = 31'h7FFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count visible one cycle after the increment is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  // Count up on i_inc, stop at all-ones, zero on i_clr.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: decodes tohost stores into pass/fail, flags timeout/hang, counts cycles/instret.
// Latency: one cycle from sampled event to status; status is sticky until clear or reset.
// Backpressure: none; purely snoops the core. Optional gp tracking: TEST_MON_GP_TRACK_EN.
import riscv_test_pkg::*;

module riscv_test_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEF,
  parameter int          TIMEOUT_CYCLES = 500,
  parameter int          HANG_CYCLES    = 64,
  parameter int          CNT_W          = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clear,
  input  logic             retire_valid,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             hang,
  output logic [30:0]      fail_testnum,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [31:0]      cur_testnum
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [30:0]  r_fail_testnum;
  logic [30:0]  w_fail_testnum_nxt;
  logic [31:0]  w_idle_cnt;
  logic [CNT_W-1:0] w_cycle_cnt;
  logic [CNT_W-1:0] w_instret_cnt;

  logic w_run;
  logic w_tohost;
  logic w_hang_hit;
  logic w_timeout_hit;

  assign w_run    = (r_state == ST_RUN);
  assign w_tohost = w_run && st_valid && (st_addr == TOHOST_ADDR) && (st_data != 32'd0);

  // Idle count reaching HANG_CYCLES-1 means this is the HANG_CYCLES-th idle cycle.
  assign w_hang_hit    = w_run && !retire_valid && (w_idle_cnt == 32'(HANG_CYCLES - 1));
  assign w_timeout_hit = w_run && (w_cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent in RUN, including the cycle the terminal event is sampled.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_clr   (clear),
    .i_inc   (w_run),
    .o_cnt   (w_cycle_cnt)
  );

  // Instructions retired while in RUN.
  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_clr   (clear),
    .i_inc   (w_run && retire_valid),
    .o_cnt   (w_instret_cnt)
  );

  // Consecutive cycles without retirement; any retire restarts the count.
  sat_counter #(.W(32)) u_idle_cnt (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_clr   (clear || retire_valid),
    .i_inc   (w_run),
    .o_cnt   (w_idle_cnt)
  );

  // Next-state: clear beats tohost, tohost beats hang, hang beats timeout.
  always_comb begin
    w_state_nxt        = r_state;
    w_fail_testnum_nxt = r_fail_testnum;
    if (clear) begin
      w_state_nxt        = ST_RUN;
      w_fail_testnum_nxt = '0;
    end else if (w_run) begin
      if (w_tohost) begin
        if (st_data == 32'd1) begin
          w_state_nxt = ST_PASS;
        end else begin
          w_state_nxt        = ST_FAIL;
          w_fail_testnum_nxt = st_data[0] ? st_data[31:1] : MALFORMED_TESTNUM;
        end
      end else if (w_hang_hit) begin
        w_state_nxt = ST_HANG;
      end else if (w_timeout_hit) begin
        w_state_nxt = ST_TIMEOUT;
      end
    end
  end

  // State and failing test number registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state        <= ST_RUN;
      r_fail_testnum <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_fail_testnum <= w_fail_testnum_nxt;
    end
  end

`ifdef TEST_MON_GP_TRACK_EN
  logic [31:0] r_cur_testnum;

  // Track the last gp write while running; frozen once a terminal state is reached.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cur_testnum <= '0;
    end else if (clear) begin
      r_cur_testnum <= '0;
    end else if (w_run && wb_en && (wb_rd == GP_REG)) begin
      r_cur_testnum <= wb_data;
    end
  end

  assign cur_testnum = r_cur_testnum;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_en, wb_rd, wb_data};
  assign cur_testnum = 32'd0;
`endif

  // Status decodes straight from the state register, so outputs stay glitch-free for LEDs.
  assign done         = (r_state != ST_RUN);
  assign pass         = (r_state == ST_PASS);
  assign fail         = (r_state == ST_FAIL);
  assign timeout      = (r_state == ST_TIMEOUT);
  assign hang         = (r_state == ST_HANG);
  assign fail_testnum = r_fail_testnum;
  assign cycle_cnt    = w_cycle_cnt;
  assign instret_cnt  = w_instret_cnt;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench for riscv_test_monitor: vector table plus directed multi-cycle sequences.
// Latency: checks one cycle after each driven input set.
// Backpressure: n/a.
module tb_riscv_test_monitor;

  localparam logic [31:0] TH = 32'h8000_1000;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        clear;
  logic        retire_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        done, pass, fail, timeout, hang;
  logic [30:0] fail_testnum;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic [31:0] cur_testnum;

  logic [4:0] flags;
  assign flags = {done, pass, fail, timeout, hang};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        retire;
    logic        stv;
    logic [31:0] addr;
    logic [31:0] data;
    logic        clr;
    logic [4:0]  exp_flags;
    logic [30:0] exp_ftn;
    int          exp_cyc;
    int          exp_ins;
  } vec_t;

  vec_t tbl[10];

  riscv_test_monitor #(
    .TOHOST_ADDR    (TH),
    .TIMEOUT_CYCLES (500),
    .HANG_CYCLES    (64),
    .CNT_W          (32)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .clear        (clear),
    .retire_valid (retire_valid),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .hang         (hang),
    .fail_testnum (fail_testnum),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt),
    .cur_testnum  (cur_testnum)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear        = 1'b0;
    retire_valid = 1'b0;
    wb_en        = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'd0;
    st_valid     = 1'b0;
    st_addr      = 32'd0;
    st_data      = 32'd0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    // {retire, st_valid, addr, data, clear, {done,pass,fail,timeout,hang}, fail_testnum, cycles, instret}
    tbl[0] = '{1'b1, 1'b1, TH,          32'd0,    1'b0, 5'b00000, 31'd0,          1, 1};
    tbl[1] = '{1'b0, 1'b1, TH + 32'd4,  32'd1,    1'b0, 5'b00000, 31'd0,          2, 1};
    tbl[2] = '{1'b1, 1'b1, TH,          32'd7,    1'b0, 5'b10100, 31'd3,          3, 2};
    tbl[3] = '{1'b1, 1'b1, TH,          32'd1,    1'b0, 5'b10100, 31'd3,          3, 2};
    tbl[4] = '{1'b1, 1'b1, TH,          32'd1,    1'b1, 5'b00000, 31'd0,          0, 0};
    tbl[5] = '{1'b1, 1'b1, TH,          32'd4,    1'b0, 5'b10100, 31'h7FFF_FFFF,  1, 1};
    tbl[6] = '{1'b0, 1'b0, TH,          32'd0,    1'b1, 5'b00000, 31'd0,          0, 0};
    tbl[7] = '{1'b0, 1'b0, TH,          32'd1,    1'b0, 5'b00000, 31'd0,          1, 0};
    tbl[8] = '{1'b1, 1'b1, TH,          32'hC9,   1'b0, 5'b10100, 31'd100,        2, 1};
    tbl[9] = '{1'b0, 1'b0, 32'd0,       32'd0,    1'b1, 5'b00000, 31'd0,          0, 0};

    idle_inputs();
    sys_rst_n = 1'b0;
    #12;
    chk("reset_flags",   {27'd0, flags}, 32'd0);
    chk("reset_cycles",  cycle_cnt, 32'd0);
    chk("reset_instret", instret_cnt, 32'd0);
    chk("reset_ftn",     {1'b0, fail_testnum}, 32'd0);
    chk("reset_gp",      cur_testnum, 32'd0);
    sys_rst_n = 1'b1;

    // Pass after 40 retiring cycles; the store cycle itself is counted.
    for (int i = 0; i < 40; i++) begin
      retire_valid = 1'b1;
      step();
    end
    st_valid = 1'b1; st_addr = TH; st_data = 32'd1;
    step();
    idle_inputs();
    chk("pass_flags",   {27'd0, flags}, 32'b11000);
    chk("pass_cycles",  cycle_cnt, 32'd41);
    chk("pass_instret", instret_cnt, 32'd41);
    retire_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pass_frozen_flags",   {27'd0, flags}, 32'b11000);
    chk("pass_frozen_cycles",  cycle_cnt, 32'd41);
    chk("pass_frozen_instret", instret_cnt, 32'd41);

    // Clear from PASS returns to RUN with everything zeroed.
    do_clear();
    chk("clear_flags",   {27'd0, flags}, 32'd0);
    chk("clear_cycles",  cycle_cnt, 32'd0);
    chk("clear_instret", instret_cnt, 32'd0);

    // Vector table: fail decoding, ignored stores, clear priority.
    for (int v = 0; v < 10; v++) begin
      idle_inputs();
      retire_valid = tbl[v].retire;
      st_valid     = tbl[v].stv;
      st_addr      = tbl[v].addr;
      st_data      = tbl[v].data;
      clear        = tbl[v].clr;
      step();
      chk($sformatf("vec%0d_flags", v),   {27'd0, flags}, {27'd0, tbl[v].exp_flags});
      chk($sformatf("vec%0d_ftn", v),     {1'b0, fail_testnum}, {1'b0, tbl[v].exp_ftn});
      chk($sformatf("vec%0d_cycles", v),  cycle_cnt, 32'(tbl[v].exp_cyc));
      chk($sformatf("vec%0d_instret", v), instret_cnt, 32'(tbl[v].exp_ins));
    end

    // Timeout with continuous retire; zero and off-address stores must not terminate.
    do_clear();
    for (int i = 1; i <= 499; i++) begin
      idle_inputs();
      retire_valid = 1'b1;
      if (i == 10) begin st_valid = 1'b1; st_addr = TH; st_data = 32'd0; end
      if (i == 20) begin st_valid = 1'b1; st_addr = TH + 32'd4; st_data = 32'd1; end
      step();
    end
    chk("pre_timeout_flags",  {27'd0, flags}, 32'd0);
    chk("pre_timeout_cycles", cycle_cnt, 32'd499);
    step();
    chk("timeout_flags",   {27'd0, flags}, 32'b10010);
    chk("timeout_cycles",  cycle_cnt, 32'd500);
    chk("timeout_instret", instret_cnt, 32'd500);
    step();
    chk("timeout_frozen_cycles", cycle_cnt, 32'd500);

    // Hang after 64 idle cycles.
    do_clear();
    for (int i = 0; i < 63; i++) step();
    chk("pre_hang_flags", {27'd0, flags}, 32'd0);
    step();
    chk("hang_flags",   {27'd0, flags}, 32'b10001);
    chk("hang_cycles",  cycle_cnt, 32'd64);
    chk("hang_instret", instret_cnt, 32'd0);

    // tohost on the would-be hang cycle wins.
    do_clear();
    for (int i = 0; i < 63; i++) step();
    st_valid = 1'b1; st_addr = TH; st_data = 32'd1;
    step();
    idle_inputs();
    chk("prio_pass_flags", {27'd0, flags}, 32'b11000);
    do_clear();
    for (int i = 0; i < 63; i++) step();
    st_valid = 1'b1; st_addr = TH; st_data = 32'd9;
    step();
    idle_inputs();
    chk("prio_fail_flags", {27'd0, flags}, 32'b10100);
    chk("prio_fail_ftn",   {1'b0, fail_testnum}, 32'd4);

    // Asynchronous reset from a terminal state, between clock edges.
    do_clear();
    retire_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    st_valid = 1'b1; st_addr = TH; st_data = 32'd7;
    step();
    idle_inputs();
    chk("pre_rst_flags", {27'd0, flags}, 32'b10100);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_flags",   {27'd0, flags}, 32'd0);
    chk("async_rst_cycles",  cycle_cnt, 32'd0);
    chk("async_rst_instret", instret_cnt, 32'd0);
    chk("async_rst_ftn",     {1'b0, fail_testnum}, 32'd0);
    #1;
    sys_rst_n = 1'b1;

    // gp tracking: x3=5, x3=6, x0=9.
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd5; step();
    wb_data = 32'd6; step();
    wb_rd = 5'd0; wb_data = 32'd9; step();
    idle_inputs();
`ifdef TEST_MON_GP_TRACK_EN
    chk("gp_track", cur_testnum, 32'd6);
`else
    chk("gp_track", cur_testnum, 32'd0);
`endif
    do_clear();
    chk("gp_clear", cur_testnum, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
